// File: rtl/led_flasher_if.sv
// LED drive bundle for led_flasher: the flasher owns the master side, board/bench the slave side.
// LED_WIDTH must match the LED_WIDTH of the led_flasher instance it is bound to.
interface led_flasher_if #(
  parameter int LED_WIDTH = 4
);
  logic [LED_WIDTH-1:0] led;

  modport master (output led);
  modport slave  (input  led);
endinterface

// File: rtl/led_flasher.sv
// Free-running board "alive" LED flasher: a prescaler tick advances the LED pattern.
// Build macro LED_FLASH_CHASE_EN selects a one-hot chase pattern instead of all-LED blink.
module led_flasher #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int FLASH_HZ    = 1,
  parameter int LED_WIDTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  led_flasher_if.master bus
);

  localparam int HALF_PERIOD = CLK_FREQ_HZ / (2 * FLASH_HZ);
  // A half period of 1 or 2 still needs a one-bit counter.
  localparam int CNT_W = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

`ifdef LED_FLASH_CHASE_EN
  localparam logic [LED_WIDTH-1:0] LED_RESET = LED_WIDTH'(1);
`else
  localparam logic [LED_WIDTH-1:0] LED_RESET = '0;
`endif

  generate
    if (HALF_PERIOD < 1) begin : g_bad_rate
      $error("led_flasher: CLK_FREQ_HZ / (2*FLASH_HZ) must be at least 1");
    end
    if (LED_WIDTH < 1) begin : g_bad_width
      $error("led_flasher: LED_WIDTH must be at least 1");
    end
  endgenerate

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic                 tick;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    led_d = led_q;
    if (tick) begin
`ifdef LED_FLASH_CHASE_EN
      // Rotate left; the shift-right term wraps the top bit and degenerates to a hold for one LED.
      led_d = (led_q << 1) | (led_q >> (LED_WIDTH - 1));
`else
      led_d = ~led_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      led_q <= LED_RESET;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign bus.led = led_q;

endmodule

// File: tb/tb_led_flasher.sv
// Scoreboard bench for led_flasher: HALF_PERIOD=5 and HALF_PERIOD=1 instances run side by side.
// Expected LED values are hand-computed per build (blink, or chase with LED_FLASH_CHASE_EN).
module tb_led_flasher;

  typedef struct {
    logic [3:0] exp;
    int         step;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t mon_a;
  exp_t mon_b;
  int   step_a = 0;
  int   step_b = 0;
  int   checks = 0;
  int   errors = 0;

  led_flasher_if #(.LED_WIDTH(4)) bus_a ();
  led_flasher_if #(.LED_WIDTH(4)) bus_b ();

  led_flasher #(.CLK_FREQ_HZ(1000), .FLASH_HZ(100), .LED_WIDTH(4)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  led_flasher #(.CLK_FREQ_HZ(2), .FLASH_HZ(1), .LED_WIDTH(4)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  // Drive rst for n edges and queue the LED value required after each of those edges.
  task automatic apply_stimulus(input bit which, input logic r, input int n, input logic [3:0] e);
    exp_t item;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (which) rst_b = r;
      else       rst_a = r;
      @(posedge clk);
      item.exp = e;
      if (which) begin
        item.step = step_b;
        step_b++;
        q_b.push_back(item);
      end else begin
        item.step = step_a;
        step_a++;
        q_a.push_back(item);
      end
    end
  endtask

  task automatic check_output(input string name, input int step, input logic [3:0] act,
                              input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: led=%b required %b", name, step, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      mon_a = q_a.pop_front();
      check_output("led_hp5", mon_a.step, bus_a.led, mon_a.exp);
    end
    if (q_b.size() > 0) begin
      mon_b = q_b.pop_front();
      check_output("led_hp1", mon_b.step, bus_b.led, mon_b.exp);
    end
  end

  task automatic drive_hp5();
`ifdef LED_FLASH_CHASE_EN
    apply_stimulus(0, 1'b1, 10, 4'b0001);
    apply_stimulus(0, 1'b0, 4,  4'b0001);
    apply_stimulus(0, 1'b0, 5,  4'b0010);
    apply_stimulus(0, 1'b0, 5,  4'b0100);
    apply_stimulus(0, 1'b0, 5,  4'b1000);
    apply_stimulus(0, 1'b0, 2,  4'b0001);
    apply_stimulus(0, 1'b1, 1,  4'b0001);
    apply_stimulus(0, 1'b0, 4,  4'b0001);
    apply_stimulus(0, 1'b0, 2,  4'b0010);
    apply_stimulus(0, 1'b1, 1,  4'b0001);
    apply_stimulus(0, 1'b0, 4,  4'b0001);
    apply_stimulus(0, 1'b0, 5,  4'b0010);
    apply_stimulus(0, 1'b0, 1,  4'b0100);
`else
    apply_stimulus(0, 1'b1, 10, 4'b0000);
    apply_stimulus(0, 1'b0, 4,  4'b0000);
    apply_stimulus(0, 1'b0, 5,  4'b1111);
    apply_stimulus(0, 1'b0, 5,  4'b0000);
    apply_stimulus(0, 1'b0, 2,  4'b1111);
    apply_stimulus(0, 1'b1, 1,  4'b0000);
    apply_stimulus(0, 1'b0, 4,  4'b0000);
    apply_stimulus(0, 1'b0, 2,  4'b1111);
    apply_stimulus(0, 1'b1, 1,  4'b0000);
    apply_stimulus(0, 1'b0, 4,  4'b0000);
    apply_stimulus(0, 1'b0, 5,  4'b1111);
    apply_stimulus(0, 1'b0, 1,  4'b0000);
`endif
  endtask

  task automatic drive_hp1();
`ifdef LED_FLASH_CHASE_EN
    apply_stimulus(1, 1'b1, 3, 4'b0001);
    apply_stimulus(1, 1'b0, 1, 4'b0010);
    apply_stimulus(1, 1'b0, 1, 4'b0100);
    apply_stimulus(1, 1'b0, 1, 4'b1000);
    apply_stimulus(1, 1'b0, 1, 4'b0001);
    apply_stimulus(1, 1'b0, 1, 4'b0010);
    apply_stimulus(1, 1'b0, 1, 4'b0100);
    apply_stimulus(1, 1'b1, 1, 4'b0001);
    apply_stimulus(1, 1'b0, 1, 4'b0010);
`else
    apply_stimulus(1, 1'b1, 3, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1, 1'b0, 1, 4'b1111);
      apply_stimulus(1, 1'b0, 1, 4'b0000);
    end
    apply_stimulus(1, 1'b0, 1, 4'b1111);
    apply_stimulus(1, 1'b1, 1, 4'b0000);
    apply_stimulus(1, 1'b0, 1, 4'b1111);
    apply_stimulus(1, 1'b0, 1, 4'b0000);
`endif
  endtask

  initial begin
    $display("[TB] led_flasher scoreboard bench starting");
    fork
      drive_hp5();
      drive_hp1();
    join
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: pending hp5=%0d hp1=%0d required 0", q_a.size(), q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
